i2s_sound_tx: RTL

Serializes the stereo sample pair produced by the synth engine mixer (`lsound_out`/`rsound_out`) onto a standard Philips I2S link toward the codec DAC. The block generates BCLK and LRCK from `data_clk` with an integer divider and double-buffers one stereo sample through a valid/ready handshake. It repeats the last frame and flags underrun when the engine misses a frame. It sits between the mixer outputs and the codec pins.

---
 rtl/i2s_sound_tx.sv | 117 +++++++++++
 1 files changed

// File: rtl/i2s_sound_tx.sv
// Philips I2S transmitter: divides data_clk into BCLK/LRCK, double-buffers one
// stereo pair behind a valid/ready handshake and repeats the last frame on underrun.
module i2s_sound_tx #(
   parameter int AUD_BIT_DEPTH = 24,
   parameter int SLOT_BITS     = 32,
   parameter int BCLK_DIV      = 8
) (
   input  logic                     data_clk,
   input  logic                     reset_data_N,
   input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
   input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
   input  logic                     sample_valid,
   output logic                     sample_ready,
   output logic                     frame_start,
   output logic                     underrun,
   output logic [15:0]              underrun_cnt,
   output logic                     i2s_bclk,
   output logic                     i2s_lrck,
   output logic                     i2s_data
);

   localparam int DIV_W = $clog2(BCLK_DIV);
   localparam int BIT_W = $clog2(2 * SLOT_BITS);
   localparam int IDX_W = $clog2(AUD_BIT_DEPTH + 1);

   logic [DIV_W-1:0]         div_cnt;
   logic [BIT_W-1:0]         bit_cnt;
   logic [BIT_W-1:0]         bit_next;
   logic [BIT_W-1:0]         slot_pos;
   logic [IDX_W-1:0]         bit_idx;
   logic [AUD_BIT_DEPTH-1:0] frame_l;
   logic [AUD_BIT_DEPTH-1:0] frame_r;
   logic [AUD_BIT_DEPTH-1:0] hold_l;
   logic [AUD_BIT_DEPTH-1:0] hold_r;
   logic [AUD_BIT_DEPTH-1:0] slot_word;
   logic                     hold_full;
   logic                     first_done;
   logic                     tick;
   logic                     load;
   logic                     accept;
   logic                     lrck_next;
   logic                     data_next;

   assign sample_ready = ~hold_full;
   assign accept       = sample_valid & ~hold_full;
   assign tick         = (div_cnt == DIV_W'(BCLK_DIV - 1));
   assign load         = tick & (bit_next == '0);

   // Slot position 0 is the idle bit after the LRCK edge; MSB follows at 1.
   always_comb begin
      bit_next  = (bit_cnt == BIT_W'(2 * SLOT_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
      lrck_next = (bit_next >= BIT_W'(SLOT_BITS));
      slot_pos  = lrck_next ? bit_next - BIT_W'(SLOT_BITS) : bit_next;
      slot_word = lrck_next ? frame_r : frame_l;
      bit_idx   = IDX_W'(AUD_BIT_DEPTH) - IDX_W'(slot_pos);
      data_next = 1'b0;
      if (slot_pos >= BIT_W'(1) && slot_pos <= BIT_W'(AUD_BIT_DEPTH))
         data_next = slot_word[bit_idx];
   end

   always_ff @(posedge data_clk or negedge reset_data_N) begin
      if (!reset_data_N) begin
         div_cnt      <= '0;
         bit_cnt      <= '0;
         i2s_bclk     <= 1'b0;
         i2s_lrck     <= 1'b0;
         i2s_data     <= 1'b0;
         frame_start  <= 1'b0;
         underrun     <= 1'b0;
         underrun_cnt <= 16'd0;
         frame_l      <= '0;
         frame_r      <= '0;
         hold_l       <= '0;
         hold_r       <= '0;
         hold_full    <= 1'b0;
         first_done   <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         underrun    <= 1'b0;

         if (tick) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
            bit_cnt  <= bit_next;
            i2s_lrck <= lrck_next;
            i2s_data <= data_next;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            if (div_cnt == DIV_W'(BCLK_DIV / 2 - 1))
               i2s_bclk <= 1'b1;
         end

         if (load) begin
            frame_start <= 1'b1;
            first_done  <= 1'b1;
            if (hold_full) begin
               frame_l   <= hold_l;
               frame_r   <= hold_r;
               hold_full <= 1'b0;
            end else if (accept) begin
               // Pair arriving on the load edge bypasses the empty holding register.
               frame_l <= lsound_in;
               frame_r <= rsound_in;
            end else if (first_done) begin
               underrun <= 1'b1;
               if (underrun_cnt != 16'hFFFF)
                  underrun_cnt <= underrun_cnt + 16'd1;
            end
         end else if (accept) begin
            hold_l    <= lsound_in;
            hold_r    <= rsound_in;
            hold_full <= 1'b1;
         end
      end
   end

endmodule
